// File: rtl/pll_reconfig_sequencer_if.sv
// Request channel of the PLL reconfiguration sequencer: one atomic VCO plus
// per-output divider/phase update, handed over with a valid/ready handshake.
interface pll_reconfig_sequencer_if #(
  parameter int NUM_OUTPUTS = 6
);
  logic                     req_valid;
  logic                     req_ready;
  logic [6:0]               req_vco_mult;
  logic [6:0]               req_vco_indiv;
  logic                     req_vco_bandwidth;
  logic [NUM_OUTPUTS-1:0]   req_out_mask;
  logic [8*NUM_OUTPUTS-1:0] req_out_div;
  logic [9*NUM_OUTPUTS-1:0] req_out_phase;

  modport master (
    output req_valid, req_vco_mult, req_vco_indiv, req_vco_bandwidth,
           req_out_mask, req_out_div, req_out_phase,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_vco_mult, req_vco_indiv, req_vco_bandwidth,
           req_out_mask, req_out_div, req_out_phase,
    output req_ready
  );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// Drives the PLL reconfiguration command sequence (start, VCO, masked outputs,
// finish) for one latched request, then waits for relock; reports done or err.
module pll_reconfig_sequencer #(
  parameter int NUM_OUTPUTS  = 6,
  parameter int CMD_TIMEOUT  = 1024,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  pll_reconfig_sequencer_if.slave    req,
  input  logic                       pll_busy,
  input  logic                       pll_locked,
  input  logic                       pll_cmd_done,
  output logic                       reconfig_start,
  output logic                       reconfig_finish,
  output logic                       reconfig_vco_en,
  output logic [6:0]                 reconfig_vco_mult,
  output logic [6:0]                 reconfig_vco_indiv,
  output logic                       reconfig_vco_bandwidth,
  output logic                       reconfig_output_en,
  output logic [2:0]                 reconfig_output_idx,
  output logic [7:0]                 reconfig_output_div,
  output logic [8:0]                 reconfig_output_phase,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic                       pll_ok
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CMD_LIMIT  = CNT_W'(CMD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       IDX_END    = 4'(NUM_OUTPUTS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_START,
    ST_VCO,
    ST_WAIT_VCO,
    ST_SCAN,
    ST_OUT_CMD,
    ST_WAIT_OUT,
    ST_FINISH,
    ST_WAIT_LOCK
  } state_e;

  state_e                   state_r;
  state_e                   state_nxt_s;
  logic [3:0]               idx_r;
  logic [3:0]               idx_nxt_s;
  logic [CNT_W-1:0]         tmo_cnt_r;
  logic                     req_ready_r;
  logic                     accept_s;
  logic                     done_s;
  logic                     err_s;
  logic [1:0]               err_code_nxt_s;
  logic                     cmd_expired_s;
  logic                     lock_expired_s;

  logic [6:0]               vco_mult_r;
  logic [6:0]               vco_indiv_r;
  logic                     vco_bw_r;
  logic [NUM_OUTPUTS-1:0]   mask_r;
  logic [8*NUM_OUTPUTS-1:0] div_r;
  logic [9*NUM_OUTPUTS-1:0] phase_r;

  logic                     mask_bit_s;
  logic [7:0]               div_sel_s;
  logic [8:0]               phase_sel_s;

  assign req.req_ready   = req_ready_r;
  assign cmd_expired_s   = (tmo_cnt_r >= CMD_LIMIT);
  assign lock_expired_s  = (tmo_cnt_r >= LOCK_LIMIT);

  // Select the mask bit and output fields addressed by the scan index.
  always_comb begin
    mask_bit_s  = 1'b0;
    div_sel_s   = 8'd0;
    phase_sel_s = 9'd0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      mask_bit_s  = (idx_r == 4'(i)) ? mask_r[i]         : mask_bit_s;
      div_sel_s   = (idx_r == 4'(i)) ? div_r[8*i +: 8]   : div_sel_s;
      phase_sel_s = (idx_r == 4'(i)) ? phase_r[9*i +: 9] : phase_sel_s;
    end
  end

  // Next-state logic of the command sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    accept_s       = 1'b0;
    done_s         = 1'b0;
    err_s          = 1'b0;
    err_code_nxt_s = 2'd0;
    case (state_r)
      ST_IDLE: begin
        if (req.req_valid && req_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: state_nxt_s = ST_WAIT_START;
      ST_WAIT_START: begin
        if (pll_busy) begin
          state_nxt_s = ST_VCO;
        end else if (cmd_expired_s) begin
          err_s          = 1'b1;
          err_code_nxt_s = 2'd1;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_START;
        end
      end
      ST_VCO: state_nxt_s = ST_WAIT_VCO;
      ST_WAIT_VCO: begin
        // cmd_done is checked first so it wins over a coincident expiry
        if (pll_cmd_done) begin
          idx_nxt_s   = 4'd0;
          state_nxt_s = ST_SCAN;
        end else if (cmd_expired_s) begin
          err_s          = 1'b1;
          err_code_nxt_s = 2'd2;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_VCO;
        end
      end
      ST_SCAN: begin
        if (idx_r == IDX_END) begin
          state_nxt_s = ST_FINISH;
        end else if (mask_bit_s) begin
          state_nxt_s = ST_OUT_CMD;
        end else begin
          idx_nxt_s   = idx_r + 4'd1;
          state_nxt_s = ST_SCAN;
        end
      end
      ST_OUT_CMD: state_nxt_s = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (pll_cmd_done) begin
          idx_nxt_s   = idx_r + 4'd1;
          state_nxt_s = ST_SCAN;
        end else if (cmd_expired_s) begin
          err_s          = 1'b1;
          err_code_nxt_s = 2'd2;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_OUT;
        end
      end
      ST_FINISH: state_nxt_s = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!pll_busy && pll_locked) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (lock_expired_s) begin
          err_s          = 1'b1;
          err_code_nxt_s = 2'd3;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 4'd0;
      end
    endcase
  end

  // Per-state timeout counter: cleared on each state change, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_nxt_s != state_r) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (tmo_cnt_r != {CNT_W{1'b1}}) begin
      tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, latched request and registered outputs (strobes fire on state entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                <= ST_IDLE;
      idx_r                  <= 4'd0;
      req_ready_r            <= 1'b0;
      vco_mult_r             <= 7'd0;
      vco_indiv_r            <= 7'd0;
      vco_bw_r               <= 1'b0;
      mask_r                 <= {NUM_OUTPUTS{1'b0}};
      div_r                  <= {(8*NUM_OUTPUTS){1'b0}};
      phase_r                <= {(9*NUM_OUTPUTS){1'b0}};
      reconfig_start         <= 1'b0;
      reconfig_finish        <= 1'b0;
      reconfig_vco_en        <= 1'b0;
      reconfig_vco_mult      <= 7'd0;
      reconfig_vco_indiv     <= 7'd0;
      reconfig_vco_bandwidth <= 1'b0;
      reconfig_output_en     <= 1'b0;
      reconfig_output_idx    <= 3'd0;
      reconfig_output_div    <= 8'd0;
      reconfig_output_phase  <= 9'd0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      err_code               <= 2'd0;
      pll_ok                 <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      req_ready_r <= (state_nxt_s == ST_IDLE);
      if (accept_s) begin
        vco_mult_r  <= req.req_vco_mult;
        vco_indiv_r <= req.req_vco_indiv;
        vco_bw_r    <= req.req_vco_bandwidth;
        mask_r      <= req.req_out_mask;
        div_r       <= req.req_out_div;
        phase_r     <= req.req_out_phase;
      end
      reconfig_start     <= (state_nxt_s == ST_START);
      reconfig_finish    <= (state_nxt_s == ST_FINISH);
      reconfig_vco_en    <= (state_nxt_s == ST_VCO);
      reconfig_output_en <= (state_nxt_s == ST_OUT_CMD);
      if (state_nxt_s == ST_VCO) begin
        reconfig_vco_mult      <= vco_mult_r;
        reconfig_vco_indiv     <= vco_indiv_r;
        reconfig_vco_bandwidth <= vco_bw_r;
      end
      if (state_nxt_s == ST_OUT_CMD) begin
        reconfig_output_idx   <= idx_r[2:0];
        reconfig_output_div   <= div_sel_s;
        reconfig_output_phase <= phase_sel_s;
      end
      done <= done_s;
      err  <= err_s;
      if (err_s) begin
        err_code <= err_code_nxt_s;
      end
      pll_ok <= pll_locked && (state_r == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench: expected command words are queued when a request is driven
// and popped as the sequencer emits strobes; a small PLL model answers them.
module tb_pll_reconfig_sequencer;

  localparam int N       = 6;
  localparam int CMD_TO  = 16;
  localparam int LOCK_TO = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pll_reconfig_sequencer_if #(.NUM_OUTPUTS(N)) rif ();

  logic       pll_busy, pll_locked, pll_cmd_done;
  logic       reconfig_start, reconfig_finish, reconfig_vco_en, reconfig_vco_bandwidth;
  logic [6:0] reconfig_vco_mult, reconfig_vco_indiv;
  logic       reconfig_output_en;
  logic [2:0] reconfig_output_idx;
  logic [7:0] reconfig_output_div;
  logic [8:0] reconfig_output_phase;
  logic       done, err, pll_ok;
  logic [1:0] err_code;

  pll_reconfig_sequencer #(
    .NUM_OUTPUTS(N), .CMD_TIMEOUT(CMD_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk(clk), .rst(rst), .req(rif),
    .pll_busy(pll_busy), .pll_locked(pll_locked), .pll_cmd_done(pll_cmd_done),
    .reconfig_start(reconfig_start), .reconfig_finish(reconfig_finish),
    .reconfig_vco_en(reconfig_vco_en), .reconfig_vco_mult(reconfig_vco_mult),
    .reconfig_vco_indiv(reconfig_vco_indiv), .reconfig_vco_bandwidth(reconfig_vco_bandwidth),
    .reconfig_output_en(reconfig_output_en), .reconfig_output_idx(reconfig_output_idx),
    .reconfig_output_div(reconfig_output_div), .reconfig_output_phase(reconfig_output_phase),
    .done(done), .err(err), .err_code(err_code), .pll_ok(pll_ok)
  );

  logic [44:0] all_outs;
  assign all_outs = {rif.req_ready, reconfig_start, reconfig_finish, reconfig_vco_en,
                     reconfig_vco_mult, reconfig_vco_indiv, reconfig_vco_bandwidth,
                     reconfig_output_en, reconfig_output_idx, reconfig_output_div,
                     reconfig_output_phase, done, err, err_code, pll_ok};

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cnt      = 0;
  int n_vco = 0, n_out = 0, n_fin = 0;
  int last_cmd_cyc = 0;
  int never_busy   = 0;
  int never_lock   = 0;
  int withhold_idx = -1;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_event(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 64'(obs), 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 64'(obs), 64'(e));
    end
  endtask

  // term: 0 done, 1 busy-never-rose, 2 cmd timeout at stop_idx, 3 lock timeout, 4 stop at stop_idx silently
  task automatic push_seq(input logic [6:0] mu, input logic [6:0] di, input logic bw,
                          input logic [N-1:0] mk, input logic [8*N-1:0] dv,
                          input logic [9*N-1:0] ph, input int stop_idx, input int term);
    exp_q.push_back(32'h1000_0000);
    if (term == 1) begin
      exp_q.push_back({4'h6, 26'd0, 2'd1});
      return;
    end
    exp_q.push_back({4'h2, 13'd0, mu, di, bw});
    for (int i = 0; i < N; i++) begin
      if (mk[i]) begin
        exp_q.push_back({4'h3, 8'd0, 3'(i), dv[8*i +: 8], ph[9*i +: 9]});
        if (i == stop_idx && term == 2) begin
          exp_q.push_back({4'h6, 26'd0, 2'd2});
          return;
        end
        if (i == stop_idx && term == 4) return;
      end
    end
    exp_q.push_back(32'h4000_0000);
    if (term == 3) exp_q.push_back({4'h6, 26'd0, 2'd3});
    else           exp_q.push_back(32'h5000_0000);
  endtask

  task automatic run_req(input logic [N-1:0] mk, input int stop_idx, input int term, input bit hold);
    logic [6:0] mu, di;
    logic bw, ok;
    logic [8*N-1:0] dv;
    logic [9*N-1:0] ph;
    mu = 7'($urandom); di = 7'($urandom); bw = 1'($urandom);
    dv = 48'({$urandom, $urandom}); ph = 54'({$urandom, $urandom});
    push_seq(mu, di, bw, mk, dv, ph, stop_idx, term);
    rif.req_vco_mult = mu; rif.req_vco_indiv = di; rif.req_vco_bandwidth = bw;
    rif.req_out_mask = mk; rif.req_out_div = dv; rif.req_out_phase = ph;
    rif.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rif.req_ready;
      @(negedge clk);
    end
    check_eq("accept_wait", 64'(ok), 64'd1);
    if (!hold) begin
      rif.req_valid = 1'b0;
      rif.req_vco_mult = 7'($urandom); rif.req_out_mask = 6'($urandom);
      rif.req_out_div = 48'({$urandom, $urandom});
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rif.req_valid && rif.req_ready) acc_cnt <= acc_cnt + 1;
  end

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (reconfig_start) begin
        sb_event("start", 32'h1000_0000);
        last_cmd_cyc = cyc;
      end
      if (reconfig_vco_en) begin
        sb_event("vco", {4'h2, 13'd0, reconfig_vco_mult, reconfig_vco_indiv, reconfig_vco_bandwidth});
        last_cmd_cyc = cyc; n_vco++;
      end
      if (reconfig_output_en) begin
        sb_event("out", {4'h3, 8'd0, reconfig_output_idx, reconfig_output_div, reconfig_output_phase});
        last_cmd_cyc = cyc; n_out++;
      end
      if (reconfig_finish) begin
        sb_event("finish", 32'h4000_0000);
        last_cmd_cyc = cyc; n_fin++;
      end
      if (done) sb_event("done", 32'h5000_0000);
      if (err) begin
        sb_event("err", {4'h6, 26'd0, err_code});
        check_eq("err_latency", 64'(cyc - last_cmd_cyc),
                 64'((err_code == 2'd3) ? LOCK_TO + 1 : CMD_TO + 1));
      end
    end
  end

  // PLL model: busy on start, cmd_done 3 cycles after each command, relock after finish.
  initial begin
    int ack_cnt, lock_cnt;
    ack_cnt = 0; lock_cnt = 0;
    pll_busy = 1'b0; pll_locked = 1'b1; pll_cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pll_busy = 1'b0; pll_locked = 1'b1; pll_cmd_done = 1'b0;
        ack_cnt = 0; lock_cnt = 0;
      end else begin
        pll_cmd_done = 1'b0;
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) pll_cmd_done = 1'b1;
        end
        if (lock_cnt > 0) begin
          lock_cnt--;
          if (lock_cnt == 0) begin
            pll_busy = 1'b0;
            pll_locked = (never_lock == 0);
          end
        end
        if (reconfig_start) begin
          pll_busy = (never_busy == 0);
          pll_locked = 1'b0;
        end
        if (reconfig_vco_en) ack_cnt = 3;
        if (reconfig_output_en && !(withhold_idx >= 0 && int'(reconfig_output_idx) == withhold_idx))
          ack_cnt = 3;
        if (reconfig_finish) lock_cnt = 2;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a0, v0, o0, f0;
    rst = 1'b1;
    rif.req_valid = 1'b0; rif.req_vco_mult = 7'd0; rif.req_vco_indiv = 7'd0;
    rif.req_vco_bandwidth = 1'b0; rif.req_out_mask = 6'd0;
    rif.req_out_div = 48'd0; rif.req_out_phase = 54'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'(all_outs), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 64'(rif.req_ready), 64'd1);
    check_eq("pll_ok_idle", 64'(pll_ok), 64'd1);

    // 1: two outputs reprogrammed
    a0 = acc_cnt;
    run_req(6'b000011, -1, 0, 1'b0);
    drain("t1", 300);
    check_eq("t1_accepts", 64'(acc_cnt - a0), 64'd1);

    // 2: empty mask
    v0 = n_vco; o0 = n_out; f0 = n_fin;
    run_req(6'b000000, -1, 0, 1'b0);
    drain("t2", 300);
    check_eq("t2_vco_cnt", 64'(n_vco - v0), 64'd1);
    check_eq("t2_out_cnt", 64'(n_out - o0), 64'd0);
    check_eq("t2_fin_cnt", 64'(n_fin - f0), 64'd1);

    // 3: busy never rises
    never_busy = 1;
    run_req(6'b000001, -1, 1, 1'b0);
    drain("t3", 300);
    check_eq("t3_ready", 64'(rif.req_ready), 64'd1);
    check_eq("t3_err_code", 64'(err_code), 64'd1);
    never_busy = 0;

    // 4: cmd_done withheld for idx2, then a clean request
    withhold_idx = 2;
    f0 = n_fin;
    run_req(6'b010111, 2, 2, 1'b0);
    drain("t4", 300);
    check_eq("t4_no_finish", 64'(n_fin - f0), 64'd0);
    check_eq("t4_err_code", 64'(err_code), 64'd2);
    withhold_idx = -1;
    run_req(6'b101000, -1, 0, 1'b0);
    drain("t4b", 300);

    // 5a: never relocks
    never_lock = 1;
    run_req(6'b100000, -1, 3, 1'b0);
    drain("t5", 300);
    check_eq("t5_err_code", 64'(err_code), 64'd3);
    check_eq("t5_pll_ok_unlocked", 64'(pll_ok), 64'd0);
    never_lock = 0;

    // 5b: reset while waiting on an output command
    withhold_idx = 0;
    run_req(6'b000001, 0, 4, 1'b0);
    drain("t5b", 300);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5b_reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    withhold_idx = -1;
    repeat (CMD_TO + 5) @(negedge clk);
    check_eq("t5b_ready", 64'(rif.req_ready), 64'd1);
    check_eq("t5b_err_code_cleared", 64'(err_code), 64'd0);

    // 6: valid held high, fields scrambled mid-sequence
    a0 = acc_cnt;
    run_req(6'b001100, -1, 0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      rif.req_vco_mult = 7'($urandom); rif.req_vco_indiv = 7'($urandom);
      rif.req_out_mask = 6'($urandom); rif.req_out_div = 48'({$urandom, $urandom});
      rif.req_out_phase = 54'({$urandom, $urandom});
      @(negedge clk);
    end
    rif.req_valid = 1'b0;
    drain("t6", 50);
    repeat (3) @(negedge clk);
    check_eq("t6_accepts", 64'(acc_cnt - a0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
